// File: rtl/decimal_key_debouncer.sv
// Decimal keypad front end: 2-flop synchroniser, debounce FSM and single-key validation.
// Optional auto-repeat of the held key is built when AUTO_REPEAT_EN is defined.
module decimal_key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] key_raw,
  output logic [9:0] d_onehot,
  output logic       d_valid,
  output logic       key_held,
  output logic       multi_err
);

  localparam int MAX_CYC = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  if (DEBOUNCE_CYCLES < 2 || CNT_W < $clog2(MAX_CYC + 1)) begin : g_bad_params
    $error("decimal_key_debouncer: DEBOUNCE_CYCLES must be >= 2 and CNT_W must hold the longest count");
  end

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t           state, state_nxt;
  logic [9:0]       key_p0, key_p1;
  logic [9:0]       ks;
  logic [9:0]       cand, cand_nxt;
  logic [9:0]       onehot_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             valid_nxt, held_nxt, err_nxt;
  logic             chord_seen, chord_nxt;
  logic             ks_is_onehot;
`ifdef AUTO_REPEAT_EN
  logic [CNT_W-1:0] rpt_cnt, rpt_nxt;
`endif

  function automatic logic is_onehot(input logic [9:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  // Stage p0/p1: two-flop synchroniser for the asynchronous key lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_p0 <= '0;
      key_p1 <= '0;
    end else begin
      key_p0 <= key_raw;
      key_p1 <= key_p0;
    end
  end

  assign ks           = key_p1;
  assign ks_is_onehot = is_onehot(ks);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cand_nxt   = cand;
    onehot_nxt = d_onehot;
    valid_nxt  = 1'b0;
    held_nxt   = key_held;
    err_nxt    = 1'b0;
    chord_nxt  = chord_seen;
`ifdef AUTO_REPEAT_EN
    rpt_nxt    = rpt_cnt;
`endif
    // A chord is reported once; only a fully released keypad re-arms the report.
    if (ks == 10'd0) chord_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (ks_is_onehot) begin
          cand_nxt  = ks;
          cnt_nxt   = CNT_ONE;
          state_nxt = DEBOUNCE;
        end else if (ks != 10'd0) begin
          err_nxt   = !chord_seen;
          chord_nxt = 1'b1;
        end
      end
      DEBOUNCE: begin
        if (ks == cand) begin
          if (cnt == DB_LAST) begin
            onehot_nxt = cand;
            valid_nxt  = 1'b1;
            held_nxt   = 1'b1;
            cnt_nxt    = '0;
            state_nxt  = PRESSED;
`ifdef AUTO_REPEAT_EN
            rpt_nxt    = '0;
`endif
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
        end else begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      PRESSED: begin
        if (ks == 10'd0) begin
          cnt_nxt   = CNT_ONE;
          state_nxt = RELEASE;
`ifdef AUTO_REPEAT_EN
          rpt_nxt   = '0;
`endif
        end
`ifdef AUTO_REPEAT_EN
        else if (ks == d_onehot) begin
          if (rpt_cnt == RPT_LAST) begin
            valid_nxt = 1'b1;
            rpt_nxt   = '0;
          end else begin
            rpt_nxt = sat_inc(rpt_cnt);
          end
        end
`endif
      end
      RELEASE: begin
        if (ks == 10'd0) begin
          if (cnt == DB_LAST) begin
            held_nxt  = 1'b0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
        end else begin
          // Bounce on release: return to the held state without a new strobe.
          cnt_nxt   = '0;
          state_nxt = PRESSED;
`ifdef AUTO_REPEAT_EN
          rpt_nxt   = '0;
`endif
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Stage p2: FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cand       <= '0;
      chord_seen <= 1'b0;
      d_onehot   <= '0;
      d_valid    <= 1'b0;
      key_held   <= 1'b0;
      multi_err  <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_cnt    <= '0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cand       <= cand_nxt;
      chord_seen <= chord_nxt;
      d_onehot   <= onehot_nxt;
      d_valid    <= valid_nxt;
      key_held   <= held_nxt;
      multi_err  <= err_nxt;
`ifdef AUTO_REPEAT_EN
      rpt_cnt    <= rpt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_decimal_key_debouncer.sv
// Bench for decimal_key_debouncer: vector table, timed corner sequences and a random run
// against a sample-history reference model.
module tb_decimal_key_debouncer;

  localparam int DB  = 4;
  localparam int RPT = 16;
`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [9:0] key_raw;
  logic [9:0] d_onehot;
  logic       d_valid;
  logic       key_held;
  logic       multi_err;

  decimal_key_debouncer #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(16),
    .REPEAT_CYCLES(RPT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_raw(key_raw),
    .d_onehot(d_onehot),
    .d_valid(d_valid),
    .key_held(key_held),
    .multi_err(multi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: raw samples delayed two clocks, then run-length rules on the samples.
  logic [9:0] m_s1, m_s2, m_cand, m_out;
  int         m_phase, m_run, m_rep;
  bit         m_pulse, m_err, m_held, m_block;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_cand = '0; m_out = '0;
    m_phase = 0; m_run = 0; m_rep = 0;
    m_pulse = 0; m_err = 0; m_held = 0; m_block = 0;
  endtask

  task automatic model_edge(input logic [9:0] raw);
    logic [9:0] s;
    s = m_s2;
    m_s2 = m_s1;
    m_s1 = raw;
    m_pulse = 0;
    m_err = 0;
    case (m_phase)
      0: begin
        if ($countones(s) == 1) begin
          m_cand = s; m_run = 1; m_phase = 1;
        end else if (s != 0) begin
          if (!m_block) m_err = 1;
          m_block = 1;
        end
      end
      1: begin
        if (s == m_cand) begin
          m_run++;
          if (m_run == DB) begin
            m_out = m_cand; m_pulse = 1; m_held = 1; m_phase = 2; m_rep = 0;
          end
        end else m_phase = 0;
      end
      2: begin
        if (s == 0) begin
          m_run = 1; m_phase = 3; m_rep = 0;
        end else if (AR && s == m_out) begin
          m_rep++;
          if (m_rep == RPT) begin m_pulse = 1; m_rep = 0; end
        end
      end
      default: begin
        if (s == 0) begin
          m_run++;
          if (m_run == DB) begin m_held = 0; m_phase = 0; end
        end else begin
          m_phase = 2; m_rep = 0;
        end
      end
    endcase
    if (s == 0) m_block = 0;
  endtask

  task automatic tick(input logic [9:0] raw);
    key_raw = raw;
    @(posedge clk);
    model_edge(raw);
    #1;
    check_eq("model d_onehot", 32'(d_onehot), 32'(m_out));
    check_eq("model d_valid", 32'(d_valid), 32'(m_pulse));
    check_eq("model key_held", 32'(key_held), 32'(m_held));
    check_eq("model multi_err", 32'(multi_err), 32'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(10'h000);
  endtask

  typedef struct {
    logic [9:0] raw;
    int         cycles;
    int         exp_vld;
    int         exp_err;
    logic [9:0] exp_onehot;
    logic       exp_held;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int when, nv, ne;
    logic [9:0] r;

    vecs.push_back('{10'h020, 14, 1, 0, 10'h020, 1'b1});
    vecs.push_back('{10'h000, 10, 0, 0, 10'h020, 1'b0});
    vecs.push_back('{10'h008,  2, 0, 0, 10'h020, 1'b0});
    vecs.push_back('{10'h000,  1, 0, 0, 10'h020, 1'b0});
    vecs.push_back('{10'h008, 14, 1, 0, 10'h008, 1'b1});
    vecs.push_back('{10'h000, 10, 0, 0, 10'h008, 1'b0});
    vecs.push_back('{10'h003,  6, 0, 1, 10'h008, 1'b0});
    vecs.push_back('{10'h000,  4, 0, 0, 10'h008, 1'b0});
    vecs.push_back('{10'h200, 14, 1, 0, 10'h200, 1'b1});
    for (int i = 0; i < 3; i++) begin
      vecs.push_back('{10'h000, 1, 0, 0, 10'h200, 1'b1});
      vecs.push_back('{10'h200, 1, 0, 0, 10'h200, 1'b1});
    end
    vecs.push_back('{10'h200,  8, 0, 0, 10'h200, 1'b1});
    vecs.push_back('{10'h000, 10, 0, 0, 10'h200, 1'b0});
    vecs.push_back('{10'h001, 14, 1, 0, 10'h001, 1'b1});
    vecs.push_back('{10'h003,  5, 0, 0, 10'h001, 1'b1});
    vecs.push_back('{10'h000, 10, 0, 0, 10'h001, 1'b0});

    // Power-on reset
    key_raw = '0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("reset d_onehot", 32'(d_onehot), 32'h0);
    check_eq("reset d_valid", 32'(d_valid), 32'h0);
    check_eq("reset key_held", 32'(key_held), 32'h0);
    check_eq("reset multi_err", 32'(multi_err), 32'h0);
    rst_n = 1'b1;
    idle(4);

    foreach (vecs[k]) begin
      nv = 0; ne = 0;
      for (int c = 0; c < vecs[k].cycles; c++) begin
        tick(vecs[k].raw);
        nv += int'(d_valid);
        ne += int'(multi_err);
      end
      check_eq($sformatf("vec%0d valid count", k), 32'(nv), 32'(vecs[k].exp_vld));
      check_eq($sformatf("vec%0d err count", k), 32'(ne), 32'(vecs[k].exp_err));
      check_eq($sformatf("vec%0d d_onehot", k), 32'(d_onehot), 32'(vecs[k].exp_onehot));
      check_eq($sformatf("vec%0d key_held", k), 32'(key_held), 32'(vecs[k].exp_held));
    end

    // Press latency, hold behaviour and release latency for key 2
    idle(6);
    when = -1;
    for (int i = 1; i <= 12; i++) begin
      tick(10'h004);
      if (d_valid === 1'b1) begin when = i; break; end
    end
    check_eq("press latency", 32'(when), 32'd6);
    check_eq("held at accept", 32'(key_held), 32'd1);
    nv = 0;
    for (int i = 0; i < 44; i++) begin
      tick(10'h004);
      nv += int'(d_valid);
      if (d_valid === 1'b1) check_eq("repeat d_onehot", 32'(d_onehot), 32'h004);
    end
    check_eq("repeats while held", 32'(nv), AR ? 32'd2 : 32'd0);
    when = -1;
    for (int i = 1; i <= 12; i++) begin
      tick(10'h000);
      if (key_held === 1'b0) begin when = i; break; end
    end
    check_eq("release latency", 32'(when), 32'd6);
    check_eq("d_onehot kept after release", 32'(d_onehot), 32'h004);

    // Chord timing and no pulse train
    idle(4);
    when = -1;
    for (int i = 1; i <= 8; i++) begin
      tick(10'h003);
      if (multi_err === 1'b1) begin when = i; break; end
    end
    check_eq("chord err latency", 32'(when), 32'd3);
    ne = 0;
    for (int i = 0; i < 8; i++) begin
      tick(10'h003);
      ne += int'(multi_err);
    end
    check_eq("chord no pulse train", 32'(ne), 32'd0);
    idle(6);

    // Reset during DEBOUNCE of key 7, key still held afterwards
    for (int i = 0; i < 4; i++) tick(10'h080);
    rst_n = 1'b0;
    #1;
    check_eq("async rst d_onehot", 32'(d_onehot), 32'h0);
    check_eq("async rst d_valid", 32'(d_valid), 32'h0);
    check_eq("async rst key_held", 32'(key_held), 32'h0);
    check_eq("async rst multi_err", 32'(multi_err), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    when = -1;
    for (int i = 1; i <= 12; i++) begin
      tick(10'h080);
      if (d_valid === 1'b1) begin when = i; break; end
    end
    check_eq("post-reset press latency", 32'(when), 32'd6);
    check_eq("post-reset d_onehot", 32'(d_onehot), 32'h080);
    idle(10);

    // Random key activity against the model
    for (int seg = 0; seg < 250; seg++) begin
      int sel, len;
      sel = $urandom_range(0, 99);
      if (sel < 40) r = 10'h000;
      else if (sel < 75) r = 10'(1 << $urandom_range(0, 9));
      else if (sel < 90) r = 10'(1 << $urandom_range(0, 9)) | 10'(1 << $urandom_range(0, 9));
      else r = 10'($urandom);
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 8);
      for (int c = 0; c < len; c++) tick(r);
    end
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
